sram_port_arbiter: RTL and testbench
====================================

# sram_port_arbiter

Shares the CPU's single sram-like memory port between the IF-stage instruction requester and the EX/MEM-stage data requester. It arbitrates address-phase requests, locks a grant until the address handshake completes, and records the requester ID of every accepted transaction in an in-order ID FIFO. Each `mem_data_ok` response is routed back to the requester that issued it. It sits between the pipeline stages (IF, EX/MEM) and the memory bridge.

## Interface
- `MAX_OUTSTANDING`, 2: depth of the ID FIFO, i.e. the maximum number of accepted but unanswered transactions (power of two, ≥2).
- `clk`  input  1  the single clock; all state updates on its rising edge.
- `resetn`  input  1  synchronous, active-low reset.
- `inst_req` / `inst_wr` / `inst_size` / `inst_addr` / `inst_wstrb` / `inst_wdata`  input  1/1/2/32/4/32  IF requester address phase.
- `inst_addr_ok`  output  1  IF request accepted this cycle.
- `inst_data_ok`  output  1  response for the oldest IF transaction.
- `inst_rdata`  output  32  read data, valid with `inst_data_ok`.
- `data_req` / `data_wr` / `data_size` / `data_addr` / `data_wstrb` / `data_wdata`  input  1/1/2/32/4/32  data requester address phase.
- `data_addr_ok` / `data_data_ok` / `data_rdata`  output  1/1/32  as for the IF requester.
- `mem_req` / `mem_wr` / `mem_size` / `mem_addr` / `mem_wstrb` / `mem_wdata`  output  1/1/2/32/4/32  shared port address phase.
- `mem_addr_ok` / `mem_data_ok` / `mem_rdata`  input  1/1/32  shared port handshakes and read data.
- `arb_err`  output  1  sticky; set on a protocol violation.

## Operation
- Slot available when the outstanding count is below `MAX_OUTSTANDING`. With no slot available, `mem_req` is 0 and neither `*_addr_ok` is asserted.
- Grant selection when unlocked: fixed priority, `data` over `inst`.
- `mem_*` address-phase outputs are a mux of the granted requester's fields. When no requester is granted they output 0.
- `mem_req` = granted requester's req & slot available.
- Lock: if `mem_req`=1 and `mem_addr_ok`=0, the grant register latches the winner. The grant stays fixed, even if the other requester has higher priority, until `mem_addr_ok`. The lock clears on the accepting edge.
- Accept (`mem_req & mem_addr_ok`):
  - push the granted ID (0=inst, 1=data) into the FIFO;
  - pulse the winner's `*_addr_ok` combinationally in the same cycle.
- Response (`mem_data_ok`):
  - pop the FIFO head;
  - assert `inst_data_ok` or `data_data_ok` per head ID;
  - route `mem_rdata` to both `*_rdata` unconditionally.
- Simultaneous accept and response: push and pop in the same edge, count unchanged. Legal even when the FIFO is full, because the pop frees a slot.
- `mem_data_ok` with the FIFO empty: no `*_data_ok` asserted, no pop, `arb_err` set.
- A locked requester dropping its req before `addr_ok`: `arb_err` set, lock released.
- FIFO pointers: log2(`MAX_OUTSTANDING`) bits, wrapping modulo depth. Count is log2(`MAX_OUTSTANDING`)+1 bits.
- Reset values:
  - all `*_addr_ok`, `*_data_ok`, `mem_req` = 0;
  - `arb_err` = 0;
  - count 0, pointers 0, lock clear;
  - round-robin last-grant = inst.

## Timing
- Address path is combinational: requester req → `mem_req` → `mem_addr_ok` → `*_addr_ok` all in the same cycle, with 0-cycle added latency.
- Response path is combinational: `mem_data_ok` → `*_data_ok` in the same cycle.
- Count, pointers, lock and `arb_err` update at the next rising edge of `clk`.
- Reset: `resetn`=0 sampled at a rising edge clears all state, including outstanding transactions mid-flight. Responses arriving after reset hit an empty FIFO and set `arb_err`; the bench must not issue them.
- Responses are strictly in order of acceptance across both requesters.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - unlocked grant alternates priority using a 1-bit last-grant register updated on every accept;
  - the requester not granted last wins when both request.
- Undefined: fixed data-over-inst priority; the last-grant register is not built.
- Lock, FIFO and error behaviour are identical in both builds.

## Test plan
- Reset then idle: all outputs 0 and count 0 after one edge with `resetn`=0.
- Both req=1 with `mem_addr_ok`=1 for one cycle:
  - fixed build: `data_addr_ok`=1, `inst_addr_ok`=0, FIFO head ID=1;
  - round-robin build: data first, then inst on the next accept.
- inst req alone with `mem_addr_ok`=0 for 3 cycles, data req rising in cycle 2: `mem_addr` stays `inst_addr` (0x1C000000) until the accept, then the data request is granted.
- Accept inst, data, then stall (`MAX_OUTSTANDING`=2): `mem_req`=0 with count 2. `mem_data_ok` twice gives `inst_data_ok` then `data_data_ok`, each carrying `mem_rdata` (0xDEADBEEF, 0x12345678).
- Full FIFO with same-cycle `mem_data_ok` and a new accept: count stays 2, popped ID routed correctly, new ID appended.
- `mem_data_ok`=1 with the FIFO empty: no `*_data_ok`, `arb_err`=1 and remains 1 until reset.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// One sram-like memory port: address phase (req/addr_ok) and data phase (data_ok/rdata).
// The master drives the address phase; the slave answers both handshakes.
`timescale 1ns/1ps
interface sram_port_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like port between the IF (inst) and EX/MEM (data) requesters, with
// in-order response routing. Define ARB_ROUND_ROBIN_EN for alternating grant priority.
`timescale 1ns/1ps
module sram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      resetn,
  sram_port_arbiter_if.slave        inst,
  sram_port_arbiter_if.slave        data,
  sram_port_arbiter_if.master       mem,
  output logic                      arb_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_t;

  lock_state_t      state, state_n;
  logic             lock_id, lock_id_n;

  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             id_fifo [MAX_OUTSTANDING];

  logic             open_id;
  logic             gnt_id;
  logic             gnt_valid;
  logic             gnt_req;
  logic             mem_req_c;
  logic             slot_avail;
  logic             accept;
  logic             pop;
  logic             head_id;
  logic             resp_err;
  logic             drop_err;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant;

  // On contention the requester that did not win the previous accept goes first.
  assign open_id = (data.req && inst.req) ? ~last_grant : data.req;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= ID_INST;
    end else if (accept) begin
      last_grant <= gnt_id;
    end
  end
`else
  assign open_id = data.req ? ID_DATA : ID_INST;
`endif

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign slot_avail = (cnt < CNT_W'(MAX_OUTSTANDING)) | pop;

  always_comb begin
    state_n   = state;
    lock_id_n = lock_id;
    gnt_id    = open_id;
    gnt_valid = inst.req | data.req;
    drop_err  = 1'b0;
    case (state)
      ST_OPEN: ;
      ST_LOCKED: begin
        gnt_id    = lock_id;
        gnt_valid = 1'b1;
      end
      default: ;
    endcase
    gnt_req   = (gnt_id == ID_DATA) ? data.req : inst.req;
    drop_err  = (state == ST_LOCKED) & ~gnt_req;
    mem_req_c = gnt_valid & gnt_req & slot_avail;
    accept    = mem_req_c & mem.addr_ok;
    if (mem_req_c && !mem.addr_ok) begin
      state_n   = ST_LOCKED;
      lock_id_n = gnt_id;
    end else begin
      state_n   = ST_OPEN;
    end
  end

  always_comb begin
    mem.req   = mem_req_c;
    mem.wr    = 1'b0;
    mem.size  = 2'b00;
    mem.addr  = 32'h0;
    mem.wstrb = 4'h0;
    mem.wdata = 32'h0;
    if (gnt_valid) begin
      if (gnt_id == ID_DATA) begin
        mem.wr    = data.wr;
        mem.size  = data.size;
        mem.addr  = data.addr;
        mem.wstrb = data.wstrb;
        mem.wdata = data.wdata;
      end else begin
        mem.wr    = inst.wr;
        mem.size  = inst.size;
        mem.addr  = inst.addr;
        mem.wstrb = inst.wstrb;
        mem.wdata = inst.wdata;
      end
    end
  end

  always_comb begin
    pop           = mem.data_ok & (cnt != '0);
    resp_err      = mem.data_ok & (cnt == '0);
    head_id       = id_fifo[rd_ptr];
    inst.addr_ok  = accept & (gnt_id == ID_INST);
    data.addr_ok  = accept & (gnt_id == ID_DATA);
    inst.data_ok  = pop & (head_id == ID_INST);
    data.data_ok  = pop & (head_id == ID_DATA);
    inst.rdata    = mem.rdata;
    data.rdata    = mem.rdata;
  end

  // ---- state register: lock, FIFO pointers/count, sticky error ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= ST_OPEN;
      lock_id <= ID_INST;
      cnt     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      arb_err <= 1'b0;
    end else begin
      state   <= state_n;
      lock_id <= lock_id_n;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      arb_err <= arb_err | resp_err | drop_err;
    end
  end

  // ID storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) id_fifo[wr_ptr] <= gnt_id;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a queue-based reference model predicts every
// cycle's outputs, a negedge monitor pops and compares them against the DUT.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic resetn;
  logic arb_err;

  sram_port_arbiter_if ib ();
  sram_port_arbiter_if db ();
  sram_port_arbiter_if mb ();

  sram_port_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .inst    (ib.slave),
    .data    (db.slave),
    .mem     (mb.master),
    .arb_err (arb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        inst_addr_ok;
    logic        data_addr_ok;
    logic        inst_data_ok;
    logic        data_data_ok;
    logic [31:0] rdata;
    logic        arb_err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: outstanding requester IDs in acceptance order, plus lock/priority state.
  int q[$];
  bit locked, lock_id, last_g, err;
  bit m_gid, m_greq, m_mreq, m_acc, m_pop, m_derr;
  bit acc_inst, acc_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_eval(output exp_t e);
    bit any_req, slot;
    any_req = ib.req || db.req;
    m_pop   = mb.data_ok && (q.size() > 0);
    m_derr  = mb.data_ok && (q.size() == 0);
    slot    = (q.size() < MAXO) || m_pop;
    if (locked) begin
      m_gid = lock_id;
    end else if (ib.req && db.req) begin
`ifdef ARB_ROUND_ROBIN_EN
      m_gid = !last_g;
`else
      m_gid = 1'b1;
`endif
    end else begin
      m_gid = db.req;
    end
    m_greq = m_gid ? db.req : ib.req;
    m_mreq = m_greq && slot;
    m_acc  = m_mreq && mb.addr_ok;
    e = '0;
    e.mem_req = m_mreq;
    if (locked || any_req) begin
      e.mem_wr    = m_gid ? db.wr    : ib.wr;
      e.mem_size  = m_gid ? db.size  : ib.size;
      e.mem_addr  = m_gid ? db.addr  : ib.addr;
      e.mem_wstrb = m_gid ? db.wstrb : ib.wstrb;
      e.mem_wdata = m_gid ? db.wdata : ib.wdata;
    end
    e.inst_addr_ok = m_acc && !m_gid;
    e.data_addr_ok = m_acc && m_gid;
    e.inst_data_ok = m_pop && (q[0] == 0);
    e.data_data_ok = m_pop && (q[0] == 1);
    e.rdata        = mb.rdata;
    e.arb_err      = err;
  endtask

  task automatic model_commit();
    if (m_pop) void'(q.pop_front());
    if (m_acc) q.push_back(int'(m_gid));
    if (m_derr || (locked && !m_greq)) err = 1'b1;
    if (m_acc) last_g = m_gid;
    acc_inst = m_acc && !m_gid;
    acc_data = m_acc && m_gid;
    locked   = m_mreq && !mb.addr_ok;
    lock_id  = m_gid;
  endtask

  task automatic model_reset();
    q.delete();
    locked = 0; lock_id = 0; last_g = 0; err = 0;
    acc_inst = 0; acc_data = 0;
  endtask

  task automatic step();
    exp_t e;
    model_eval(e);
    exp_q.push_back(e);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic drive(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                       input bit aok, input bit dok, input logic [31:0] rd);
    ib.req = ir; ib.wr = 1'b0; ib.size = 2'd2; ib.addr = ia; ib.wstrb = 4'h0; ib.wdata = 32'h0;
    db.req = dr; db.wr = 1'b1; db.size = 2'd2; db.addr = da; db.wstrb = 4'hF; db.wdata = 32'hA5A5_0000 ^ da;
    mb.addr_ok = aok; mb.data_ok = dok; mb.rdata = rd;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    resetn = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("mem_req",      32'(mb.req),       32'(e.mem_req));
      check("mem_addr",     mb.addr,           e.mem_addr);
      check("mem_ctl",      {25'h0, mb.wr, mb.size, mb.wstrb}, {25'h0, e.mem_wr, e.mem_size, e.mem_wstrb});
      check("mem_wdata",    mb.wdata,          e.mem_wdata);
      check("addr_ok",      {30'h0, ib.addr_ok, db.addr_ok}, {30'h0, e.inst_addr_ok, e.data_addr_ok});
      check("data_ok",      {30'h0, ib.data_ok, db.data_ok}, {30'h0, e.inst_data_ok, e.data_data_ok});
      check("inst_rdata",   ib.rdata,          e.rdata);
      check("data_rdata",   db.rdata,          e.rdata);
      check("arb_err",      32'(arb_err),      32'(e.arb_err));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);                                  step();  // idle after reset

    // Contention with immediate accept, then the loser on the next accept.
    drive(1, 32'h1C00_0100, 1, 32'h8000_0100, 1, 0, 0);          step();
    drive(1, 32'h1C00_0100, 0, 0, 1, 0, 0);                       step();
    drive(0, 0, 0, 0, 0, 1, 32'h1111_2222);                       step();
    drive(0, 0, 0, 0, 0, 1, 32'h3333_4444);                       step();

    // Lock held on inst while data rises, then data granted after the accept.
    drive(1, 32'h1C00_0000, 0, 0, 0, 0, 0);                       step();
    drive(1, 32'h1C00_0000, 1, 32'h8000_1000, 0, 0, 0);           step();
    drive(1, 32'h1C00_0000, 1, 32'h8000_1000, 0, 0, 0);           step();
    drive(1, 32'h1C00_0000, 1, 32'h8000_1000, 1, 0, 0);           step();
    drive(0, 0, 1, 32'h8000_1000, 1, 0, 0);                       step();
    // Full: stall, then pop+push in one cycle, then drain.
    drive(1, 32'h1C00_0004, 0, 0, 1, 0, 0);                       step();
    drive(1, 32'h1C00_0004, 0, 0, 1, 1, 32'hDEAD_BEEF);           step();
    drive(0, 0, 0, 0, 0, 1, 32'h1234_5678);                       step();
    drive(0, 0, 0, 0, 0, 1, 32'h0BAD_F00D);                       step();
    drive(0, 0, 0, 0, 0, 0, 0);                                   step();

    // Response with empty FIFO: sticky error until reset.
    drive(0, 0, 0, 0, 0, 1, 32'hCAFE_0001);                       step();
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0);                  step(); end
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);                                   step();

    // Locked requester dropping req.
    drive(1, 32'h1C00_0040, 0, 0, 0, 0, 0);                       step();
    drive(0, 0, 0, 0, 0, 0, 0);                                   step();
    drive(0, 0, 0, 0, 0, 0, 0);                                   step();
    do_reset();

    // Randomized legal traffic: requesters hold until accepted, responses only when outstanding.
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if (!ib.req || acc_inst) begin
        ib.req = ($urandom_range(0, 9) < 4);
        ib.wr = 1'($urandom); ib.size = 2'($urandom); ib.addr = $urandom;
        ib.wstrb = 4'($urandom); ib.wdata = $urandom;
      end
      if (!db.req || acc_data) begin
        db.req = ($urandom_range(0, 9) < 4);
        db.wr = 1'($urandom); db.size = 2'($urandom); db.addr = $urandom;
        db.wstrb = 4'($urandom); db.wdata = $urandom;
      end
      mb.addr_ok = 1'($urandom_range(0, 1));
      mb.data_ok = (q.size() > 0) && ($urandom_range(0, 2) != 0);
      mb.rdata   = $urandom;
      step();
    end

    @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
